// File: rtl/hpdcache_demux_pkg.sv
// Shared helpers for the hpdcache stream demultiplexer.
// The one-hot selector checks work on a fixed-width vector, which caps NOUTPUT at MAX_OUTPUTS.
package hpdcache_demux_pkg;

  localparam int unsigned MAX_OUTPUTS = 32;

  typedef logic [MAX_OUTPUTS-1:0] wide_vec_t;

  function automatic logic is_one_hot(input wide_vec_t v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // Index of the highest set bit; only meaningful when is_one_hot() holds.
  function automatic int unsigned one_hot_index(input wide_vec_t v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_OUTPUTS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hpdcache_demux_slot.sv
// Single-entry elastic buffer for one demux output.
// It can accept a new entry while its current entry drains, so there is no bubble.
module hpdcache_demux_slot
  import hpdcache_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  can_load
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hpdcache_demux.sv
// Registered valid/ready demultiplexer: one input stream fans out to NOUTPUT buffered outputs.
// Transactions carrying an invalid selector are consumed, dropped and reported on sel_err_o.
module hpdcache_demux
  import hpdcache_demux_pkg::*;
#(
  parameter  int unsigned NOUTPUT     = 2,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  bit          ONE_HOT_SEL = 1'b0,
  localparam int unsigned SEL_WIDTH   = ONE_HOT_SEL ? NOUTPUT : $clog2(NOUTPUT)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [SEL_WIDTH-1:0]                in_sel_i,
  input  logic [DATA_WIDTH-1:0]               in_data_i,
  output logic [NOUTPUT-1:0]                  out_valid_o,
  input  logic [NOUTPUT-1:0]                  out_ready_i,
  output logic [NOUTPUT-1:0][DATA_WIDTH-1:0]  out_data_o,
  output logic                                sel_err_o
);

  localparam int unsigned IDX_WIDTH = $clog2(NOUTPUT);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SEL_WIDTH-1:0]  sel_t;
  typedef logic [IDX_WIDTH-1:0]  idx_t;

  logic         sel_ok;
  idx_t         target;
  logic [NOUTPUT-1:0] load;
  logic [NOUTPUT-1:0] can_load;
  sel_t         sel;
  data_t        data;

  assign sel  = in_sel_i;
  assign data = in_data_i;

  if (ONE_HOT_SEL) begin : g_one_hot
    always_comb begin
      sel_ok = is_one_hot(MAX_OUTPUTS'(sel));
      target = IDX_WIDTH'(one_hot_index(MAX_OUTPUTS'(sel)));
    end
  end else begin : g_binary
    always_comb begin
      sel_ok = (32'(sel) < NOUTPUT);
      target = sel;
    end
  end

  // An invalid selector is always accepted so a bad transaction can never wedge the input.
  assign in_ready_o = sel_ok ? can_load[target] : 1'b1;

  for (genvar k = 0; k < NOUTPUT; k++) begin : g_slot
    assign load[k] = in_valid_i && sel_ok && can_load[k] && (target == IDX_WIDTH'(k));

    hpdcache_demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) i_slot (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .load      (load[k]),
      .load_data (data),
      .ready     (out_ready_i[k]),
      .valid     (out_valid_o[k]),
      .data      (out_data_o[k]),
      .can_load  (can_load[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_err_o <= 1'b0;
    end else begin
      sel_err_o <= in_valid_i && !sel_ok;
    end
  end

endmodule

// File: tb/tb_hpdcache_demux.sv
// Self-checking bench for hpdcache_demux: a 4-output binary instance driven by a vector table,
// plus a 3-output binary and a 4-output one-hot instance exercised by hand-written sequences.
module tb_hpdcache_demux;

  logic clk;
  logic rst_n;

  logic            m_valid, m_rdy, m_err;
  logic [1:0]      m_sel;
  logic [7:0]      m_data;
  logic [3:0]      m_ov, m_ordy;
  logic [3:0][7:0] m_od;

  logic            t_valid, t_rdy, t_err;
  logic [1:0]      t_sel;
  logic [7:0]      t_data;
  logic [2:0]      t_ov, t_ordy;
  logic [2:0][7:0] t_od;

  logic            h_valid, h_rdy, h_err;
  logic [3:0]      h_sel;
  logic [7:0]      h_data;
  logic [3:0]      h_ov, h_ordy;
  logic [3:0][7:0] h_od;

  int errors = 0;
  int checks = 0;

  hpdcache_demux #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b0)) dut_main (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(m_valid), .in_ready_o(m_rdy),
    .in_sel_i(m_sel), .in_data_i(m_data), .out_valid_o(m_ov), .out_ready_i(m_ordy),
    .out_data_o(m_od), .sel_err_o(m_err)
  );

  hpdcache_demux #(.NOUTPUT(3), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b0)) dut_three (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(t_valid), .in_ready_o(t_rdy),
    .in_sel_i(t_sel), .in_data_i(t_data), .out_valid_o(t_ov), .out_ready_i(t_ordy),
    .out_data_o(t_od), .sel_err_o(t_err)
  );

  hpdcache_demux #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b1)) dut_hot (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(h_valid), .in_ready_o(h_rdy),
    .in_sel_i(h_sel), .in_data_i(h_data), .out_valid_o(h_ov), .out_ready_i(h_ordy),
    .out_data_o(h_od), .sel_err_o(h_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  typedef struct {
    logic       valid;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [1:0] idx;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one vector mid-cycle, check the combinational ready, then the registered outputs after the edge.
  task automatic apply_stimulus(input vec_t v, input int n);
    @(negedge clk);
    m_valid = v.valid;
    m_sel   = v.sel;
    m_data  = v.data;
    m_ordy  = v.ordy;
    #1;
    check_output($sformatf("vec%0d in_ready", n), 32'(m_rdy), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d out_valid", n), 32'(m_ov), 32'(v.exp_ov));
    check_output($sformatf("vec%0d out_data", n), 32'(m_od[v.idx]), 32'(v.exp_d));
    check_output($sformatf("vec%0d sel_err", n), 32'(m_err), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 8'hA1, 4'b1111, 1'b1, 4'b0100, 2'd2, 8'hA1};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd2, 8'hA1};
    vecs[2]  = '{1'b1, 2'd1, 8'h10, 4'b1111, 1'b1, 4'b0010, 2'd1, 8'h10};
    vecs[3]  = '{1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 2'd1, 8'h11};
    vecs[4]  = '{1'b1, 2'd1, 8'h12, 4'b1111, 1'b1, 4'b0010, 2'd1, 8'h12};
    vecs[5]  = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd1, 8'h12};
    vecs[6]  = '{1'b1, 2'd3, 8'h30, 4'b0111, 1'b1, 4'b1000, 2'd3, 8'h30};
    vecs[7]  = '{1'b1, 2'd3, 8'h31, 4'b0111, 1'b0, 4'b1000, 2'd3, 8'h30};
    vecs[8]  = '{1'b1, 2'd0, 8'h05, 4'b0110, 1'b1, 4'b1001, 2'd0, 8'h05};
    vecs[9]  = '{1'b1, 2'd3, 8'h31, 4'b1111, 1'b1, 4'b1000, 2'd3, 8'h31};
    vecs[10] = '{1'b0, 2'd3, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd3, 8'h31};

    rst_n = 1'b0;
    m_valid = 1'b0; m_sel = '0; m_data = '0; m_ordy = '1;
    t_valid = 1'b0; t_sel = '0; t_data = '0; t_ordy = '1;
    h_valid = 1'b0; h_sel = '0; h_data = '0; h_ordy = '1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset main out_valid", 32'(m_ov), 32'h0);
    check_output("reset main out_data", 32'(m_od), 32'h0);
    check_output("reset main sel_err", 32'(m_err), 32'h0);
    check_output("reset three out_valid", 32'(t_ov), 32'h0);
    check_output("reset hot out_valid", 32'(h_ov), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i], i);
    @(negedge clk);
    m_valid = 1'b0;

    // Binary selector beyond NOUTPUT: consumed, dropped, single-cycle error pulse.
    @(negedge clk);
    t_valid = 1'b1; t_sel = 2'd3; t_data = 8'h99; t_ordy = 3'b111;
    #1;
    check_output("three bad sel in_ready", 32'(t_rdy), 32'h1);
    @(posedge clk); #1;
    check_output("three bad sel out_valid", 32'(t_ov), 32'h0);
    check_output("three bad sel sel_err", 32'(t_err), 32'h1);
    @(negedge clk);
    t_sel = 2'd2; t_data = 8'h22;
    #1;
    check_output("three good sel in_ready", 32'(t_rdy), 32'h1);
    @(posedge clk); #1;
    check_output("three good sel out_valid", 32'(t_ov), 32'b100);
    check_output("three good sel out_data", 32'(t_od[2]), 32'h22);
    check_output("three err pulse ends", 32'(t_err), 32'h0);
    @(negedge clk);
    t_valid = 1'b0;
    @(posedge clk); #1;
    check_output("three drained", 32'(t_ov), 32'h0);

    // One-hot selector: two-hot and zero are invalid, a single bit routes.
    @(negedge clk);
    h_valid = 1'b1; h_sel = 4'b0110; h_data = 8'hEE;
    #1;
    check_output("hot two-hot in_ready", 32'(h_rdy), 32'h1);
    @(posedge clk); #1;
    check_output("hot two-hot sel_err", 32'(h_err), 32'h1);
    check_output("hot two-hot out_valid", 32'(h_ov), 32'h0);
    @(negedge clk);
    h_sel = 4'b0000;
    #1;
    check_output("hot zero in_ready", 32'(h_rdy), 32'h1);
    @(posedge clk); #1;
    check_output("hot zero sel_err", 32'(h_err), 32'h1);
    @(negedge clk);
    h_sel = 4'b1000; h_data = 8'h7E;
    @(posedge clk); #1;
    check_output("hot sel3 out_valid", 32'(h_ov), 32'b1000);
    check_output("hot sel3 out_data", 32'(h_od[3]), 32'h7E);
    check_output("hot sel3 sel_err", 32'(h_err), 32'h0);
    @(negedge clk);
    h_sel = 4'b0001; h_data = 8'h11; h_ordy = 4'b0000;
    @(posedge clk); #1;
    check_output("hot sel0 out_valid", 32'(h_ov), 32'b1001);
    @(negedge clk);
    h_data = 8'h12;
    #1;
    check_output("hot sel0 stall in_ready", 32'(h_rdy), 32'h0);
    @(posedge clk); #1;
    check_output("hot sel0 held data", 32'(h_od[0]), 32'h11);
    @(negedge clk);
    h_valid = 1'b0; h_ordy = 4'b1111;

    // Fill every main buffer, then reset asynchronously between clock edges.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_valid = 1'b1; m_sel = 2'(k); m_data = 8'(8'h40 + k); m_ordy = 4'b0000;
    end
    @(posedge clk); #1;
    check_output("fill out_valid", 32'(m_ov), 32'hF);
    check_output("fill out_data", 32'(m_od), 32'h43424140);
    @(negedge clk);
    m_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset out_valid", 32'(m_ov), 32'h0);
    check_output("async reset out_data", 32'(m_od), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b1; m_sel = 2'd0; m_data = 8'h55; m_ordy = 4'b1111;
    @(posedge clk); #1;
    check_output("post reset out_valid", 32'(m_ov), 32'b0001);
    check_output("post reset out_data", 32'(m_od[0]), 32'h55);
    @(negedge clk);
    m_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
